// File: rtl/fwd_scoreboard_if.sv
// Issue/operand bundle between the ID stage and the forwarding scoreboard.
// Latency: none; this is wiring only.
// Backpressure: ID observes stall and holds its instruction while it is high.
//
// Ports (master = ID stage, slave = scoreboard):
//   issue_valid/issue_we/issue_rd/issue_lat : instruction requesting entry into EX
//   src_reg/src_used                        : source operands of that instruction
//   flush                                   : kill the ID instruction this cycle
//   stall                                   : combinational interlock back to ID
//   fwd_sel                                 : registered per-operand forward selects for EX
//   stall_cnt                               : saturating stall-cycle counter
interface fwd_scoreboard_if #(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3,
  parameter int SELW   = $clog2(DEPTH + 1)
);
  logic                   issue_valid;
  logic                   issue_we;
  logic [REG_AW-1:0]      issue_rd;
  logic [SELW-1:0]        issue_lat;
  logic [NSRC*REG_AW-1:0] src_reg;
  logic [NSRC-1:0]        src_used;
  logic                   flush;
  logic                   stall;
  logic [NSRC*SELW-1:0]   fwd_sel;
  logic [15:0]            stall_cnt;

  modport master (
    output issue_valid, issue_we, issue_rd, issue_lat, src_reg, src_used, flush,
    input  stall, fwd_sel, stall_cnt
  );

  modport slave (
    input  issue_valid, issue_we, issue_rd, issue_lat, src_reg, src_used, flush,
    output stall, fwd_sel, stall_cnt
  );
endinterface

// File: rtl/fwd_scoreboard.sv
// Operand-forwarding scoreboard and load-use interlock sitting between ID and EX.
// Latency: stall is combinational; fwd_sel is registered, 1 cycle after accept.
// Backpressure: stall holds ID and injects a bubble until every matched producer is ready.
//
// Ports:
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : slave side of fwd_scoreboard_if (issue request, operands, flush,
//                stall, fwd_sel, stall_cnt)
module fwd_scoreboard #(
  parameter int REG_AW = 5,
  parameter int NSRC   = 2,
  parameter int DEPTH  = 3,
  parameter int SELW   = $clog2(DEPTH + 1)
) (
  input  logic           clk,
  input  logic           rst_n,
  fwd_scoreboard_if.slave bus
);

  // slot[k] describes the instruction accepted k cycles ago.
  logic [DEPTH:1]    slotVld;
  logic [REG_AW-1:0] slotRd  [1:DEPTH];
  logic [SELW-1:0]   slotLat [1:DEPTH];

  logic [SELW-1:0]      issueLat;
  logic [NSRC-1:0]      opBlocked;
  logic [NSRC*SELW-1:0] matchSel;
  logic                 stallInt;
  logic                 accept;
  logic [NSRC*SELW-1:0] fwdSelQ;
  logic [15:0]          stallCntQ;

  // Clamp the declared result latency into 1..DEPTH.
  always_comb begin
    issueLat = bus.issue_lat;
    if (bus.issue_lat == '0) begin
      issueLat = SELW'(1);
    end else if (bus.issue_lat > SELW'(DEPTH)) begin
      issueLat = SELW'(DEPTH);
    end
  end

  // Scan oldest to youngest so the youngest producer overwrites any older
  // match; its readiness alone decides whether the operand is blocked.
  always_comb begin
    matchSel  = '0;
    opBlocked = '0;
    for (int i = 0; i < NSRC; i++) begin
      if (bus.src_used[i] && (bus.src_reg[i*REG_AW +: REG_AW] != '0)) begin
        for (int k = DEPTH; k >= 1; k--) begin
          if (slotVld[k] && (slotRd[k] == bus.src_reg[i*REG_AW +: REG_AW])) begin
            matchSel[i*SELW +: SELW] = SELW'(k);
            opBlocked[i]             = (slotLat[k] > SELW'(k));
          end
        end
      end
    end
  end

  assign stallInt = ~bus.flush & bus.issue_valid & (|opBlocked);
  assign accept   = bus.issue_valid & ~stallInt & ~bus.flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slotVld   <= '0;
      for (int k = 1; k <= DEPTH; k++) begin
        slotRd[k]  <= '0;
        slotLat[k] <= '0;
      end
      fwdSelQ   <= '0;
      stallCntQ <= '0;
    end else begin
      for (int k = DEPTH; k >= 2; k--) begin
        slotVld[k] <= slotVld[k-1];
        slotRd[k]  <= slotRd[k-1];
        slotLat[k] <= slotLat[k-1];
      end
      // Stalls, flushes, non-writers and writes to r0 all enter as bubbles.
      slotVld[1] <= accept & bus.issue_we & (bus.issue_rd != '0);
      slotRd[1]  <= bus.issue_rd;
      slotLat[1] <= issueLat;

      fwdSelQ <= accept ? matchSel : '0;

      if (stallInt && (stallCntQ != 16'hFFFF)) begin
        stallCntQ <= stallCntQ + 16'd1;
      end
    end
  end

  assign bus.stall     = stallInt;
  assign bus.fwd_sel   = fwdSelQ;
  assign bus.stall_cnt = stallCntQ;

endmodule

// File: doc/fwd_scoreboard.md
# fwd_scoreboard

Parametrised operand-forwarding and load-use interlock unit for the MIPS pipeline. It sits between ID and EX and tracks every in-flight register write for DEPTH cycles after issue, together with the cycle at which each result becomes forwardable. From that it produces registered per-operand forward selects for EX, plus a combinational stall when a needed result is not yet ready. It generalises the fixed EX/MEM/WB two-operand forwarding to NSRC operands, DEPTH forwarding stages and per-instruction result latency, and adds a saturating stall-cycle counter.

## Interface
- REG_AW, 5, register index width
- NSRC, 2, source operands checked per instruction
- DEPTH, 3, forwarding stages tracked after issue (EX/MEM, MEM/WB, WB/late); must be 1..7
- SELW, $clog2(DEPTH+1), width of one forward select
- clk  in  1  clock, all state updates on rising edge
- rst_n  in  1  asynchronous active-low reset
- issue_valid  in  1  instruction in ID requests to enter EX this cycle
- issue_we  in  1  that instruction writes a register
- issue_rd  in  REG_AW  its destination register
- issue_lat  in  SELW  age L at which its result is on forward bus L (1 = ALU, 2 = load); 0 treated as 1; >DEPTH treated as DEPTH
- src_reg  in  NSRC*REG_AW  source registers of the ID instruction, operand i at bits [i*REG_AW +: REG_AW]
- src_used  in  NSRC  operand i is actually read
- flush  in  1  kill the ID instruction this cycle
- stall  out  1  hold IF/ID, insert bubble into EX (combinational)
- fwd_sel  out  NSRC*SELW  registered, valid while the consumer is in EX; 0 = register file, j = forward bus j (result of instruction issued j cycles earlier)
- stall_cnt  out  16  saturating count of stall cycles

## Operation
- Slot array slot[1..DEPTH], each {valid, rd, lat}. slot[k] holds the instruction accepted k cycles ago.
- accept = issue_valid & ~stall & ~flush.
- Every clock: slot[k+1] <= slot[k] for k < DEPTH. slot[DEPTH] is discarded.
- Every clock: slot[1] <= {accept & issue_we & (issue_rd != 0), issue_rd, clamped lat}. A bubble enters as valid = 0.
- Per operand i with src_used[i] and src_reg[i] != 0, the match is the smallest k with slot[k].valid and slot[k].rd == src_reg[i]. The youngest producer always wins, even when an older one is ready.
- Operand i is blocked if it has a match k with slot[k].lat > k.
- stall = ~flush & issue_valid & (any operand blocked).
- Register 0 never matches. Unused operands never match and never stall.
- fwd_sel[i] <= accept ? (match k, or 0 if none) : 0. Bubbles leave EX with all selects 0.
- A producer older than DEPTH cycles is assumed written back. Its operand gets select 0 (register file, write-before-read).
- stall_cnt increments on every cycle with stall = 1 and saturates at 16'hFFFF. It is never cleared except by reset.

## Timing
- Reset (rst_n = 0, asynchronous) clears all slots valid = 0, fwd_sel = 0 and stall_cnt = 0. With slots empty, stall = 0 immediately.
- stall is combinational from inputs and slot state in the same cycle. fwd_sel has 1-cycle latency from accept.
- Load-use with lat = 2 and back-to-back consumer: exactly 1 stall cycle, then fwd_sel = 2.
- In general, stall lasts L - k cycles, because the producer ages by one per bubble.
- Flush together with stall: flush wins. stall = 0, no slot entry, fwd_sel = 0, stall_cnt not incremented.
- Reset asserted mid-stall: stall drops in the same cycle and all state is cleared.
- Simultaneous match on both operands to different slots: each operand is resolved independently. stall if either is blocked.

## Test plan
- ALU back-to-back (DEPTH = 3, NSRC = 2): accept rd = 8, lat = 1. Next cycle src0 = 8 -> stall = 0, and the following cycle fwd_sel[0] = 1, fwd_sel[1] = 0.
- Load-use: accept rd = 9, lat = 2. Next cycle src1 = 9 -> stall = 1 for one cycle, stall_cnt = 1. Then accepted with fwd_sel[1] = 2.
- Youngest priority: accept rd = 5 at t and rd = 5 at t+1, both lat = 1. Consumer at t+2 src0 = 5 -> fwd_sel[0] = 1, not 2.
- Zero/unused operands: accept rd = 0 with we = 1. Then src0 = 0 -> no stall, select 0. Also src1 = 8 matching with src_used[1] = 0 -> select 0.
- Aging: accept rd = 4, then 2 bubbles, then consumer src0 = 4 -> fwd_sel[0] = 3. With 3 bubbles -> fwd_sel[0] = 0.
- Boundary cases:
  - Flush during load-use stall -> stall = 0 that cycle and stall_cnt unchanged.
  - rst_n low during a stall -> stall, fwd_sel and stall_cnt all 0 without waiting for a clock edge.
  - Holding 65540 stall cycles -> stall_cnt = 16'hFFFF.
